sc_s2b_counter: RTL and testbench

SC_S2B_COUNTER -- requirements
Module: sc_s2b_counter

---
 rtl/sc_pkg.sv | 26 ++
 rtl/sc_window_ctr.sv | 40 ++++
 rtl/sc_s2b_counter.sv | 105 ++++++++++
 tb/tb_sc_s2b_counter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_pkg
// Description : Shared stochastic-computing types: converter FSM state and
//               the clogb2 ceiling-log2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } sc_state_t;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_window_ctr.sv
`default_nettype none
// ============================================================================
// Module      : sc_window_ctr
// Description : Valid-gated window counter with a terminal-count flag that
//               marks the increment completing a 2^WINDOW_LOG2-bit window.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_window_ctr #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [WINDOW_LOG2:0] c_window = {1'b1, {WINDOW_LOG2{1'b0}}};
    localparam logic [WINDOW_LOG2:0] c_one    = {{WINDOW_LOG2{1'b0}}, 1'b1};

    logic [WINDOW_LOG2:0] r_count;
    logic [WINDOW_LOG2:0] w_next;

    assign w_next = r_count + c_one;

    // The extra MSB lets the count reach 2^WINDOW_LOG2 without wrapping.
    assign o_tc = i_inc && (w_next == c_window);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sc_s2b_counter.sv
`default_nettype none
// ============================================================================
// Module      : sc_s2b_counter
// Description : Stochastic-to-binary converter: counts ones over a window of
//               2^WINDOW_LOG2 valid bits. Define SC_S2B_AUTORESTART_EN for
//               back-to-back windows after a single start.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_s2b_counter
    import sc_pkg::*;
#(
    parameter int WINDOW_LOG2   = 8,
    parameter int INPUT_STREAMS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_bit,
    input  logic                   in_valid,
    output logic                   busy,
    output logic                   out_valid,
    output logic [WINDOW_LOG2:0]   result
);

    if ((INPUT_STREAMS < 2) || ((1 << clogb2(INPUT_STREAMS)) != INPUT_STREAMS)) begin : g_bad_input_streams
        $error("sc_s2b_counter: INPUT_STREAMS must be a power of 2 and at least 2");
    end

    sc_state_t            r_state;
    logic [WINDOW_LOG2:0] r_acc;
    logic [WINDOW_LOG2:0] r_result;
    logic                 r_busy;
    logic                 r_out_valid;

    logic                 w_clear;
    logic                 w_inc;
    logic                 w_tc;
    logic [WINDOW_LOG2:0] w_acc_next;

    assign w_clear    = ((r_state == IDLE) && start) || (r_state == DONE);
    assign w_inc      = (r_state == ACCUM) && in_valid;
    assign w_acc_next = r_acc + {{WINDOW_LOG2{1'b0}}, in_bit};

    sc_window_ctr #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_window_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_inc   (w_inc),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_acc <= w_acc_next;
                        // The final bit of the window lands directly in result.
                        if (w_tc) begin
                            r_result    <= w_acc_next;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
`ifdef SC_S2B_AUTORESTART_EN
                    r_acc   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= ACCUM;
`else
                    r_state <= IDLE;
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sc_s2b_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_s2b_counter
// Description : Self-checking bench for sc_s2b_counter (16-bit window DUT plus
//               a 256-bit window DUT fed by an inline 2-input mux adder).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_s2b_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       busy;
    logic       out_valid;
    logic [4:0] result;

    logic       start8 = 1'b0;
    logic       bit8 = 1'b0;
    logic       valid8 = 1'b0;
    logic       busy8;
    logic       ov8;
    logic [8:0] result8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int prev_result = 0;

    typedef struct {
        int res;
        int cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int pattern;
        int stall;
        int mid_start;
        int done_start;
        int exp_result;
    } win_vec_t;
    win_vec_t tbl[5];

    sc_s2b_counter #(.WINDOW_LOG2(4), .INPUT_STREAMS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result)
    );

    sc_s2b_counter #(.WINDOW_LOG2(8), .INPUT_STREAMS(2)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .in_bit    (bit8),
        .in_valid  (valid8),
        .busy      (busy8),
        .out_valid (ov8),
        .result    (result8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input int p, input int n);
        case (p)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (n % 2) == 0;
            3:       return (n % 4) == 3;
            default: return n < 5;
        endcase
    endfunction

    // Scoreboard consumer: every pulse must match the oldest expected window.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", int'(result), e.res);
                check("pulse_cycle", cyc, e.cyc);
                check("busy_in_done", int'(busy), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_window(input win_vec_t v);
        int  n;
        int  k;
        bit  mid_done;
        n = 0;
        k = 0;
        mid_done = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        while (n < 16) begin
            if (n == 8 && !mid_done) begin
                check("result_held_mid", int'(result), prev_result);
                check("busy_mid", int'(busy), 1);
                mid_done = 1;
            end
            in_valid = !(v.stall != 0 && (k % 3) == 2);
            in_bit   = pat_bit(v.pattern, n);
            start    = (v.mid_start != 0) && (k % 5 == 1);
            if (in_valid && n == 15) sb.push_back('{v.exp_result, cyc + 1});
            step();
            if (in_valid) n++;
            k++;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        start    = (v.done_start != 0);
        step();
        start = 1'b0;
        check("busy_after_done", int'(busy), 0);
        check("out_valid_after_done", int'(out_valid), 0);
        step();
        check("busy_idle", int'(busy), 0);
        check("result_hold", int'(result), v.exp_result);
        prev_result = v.exp_result;
    endtask

    initial begin
        logic [15:0] la;
        logic [15:0] lb;
        logic [15:0] lc;
        int          cnt8;
        logic        a;
        logic        b;

        tbl[0] = '{1, 0, 0, 0, 16};
        tbl[1] = '{2, 1, 0, 0, 8};
        tbl[2] = '{0, 0, 1, 0, 0};
        tbl[3] = '{3, 1, 1, 1, 4};
        tbl[4] = '{4, 0, 0, 0, 5};

        step();
        step();
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);

`ifndef SC_S2B_AUTORESTART_EN
        for (int i = 0; i < 5; i++) run_window(tbl[i]);
`endif

        // Abort after 7 valid bits; rst also wins over a simultaneous start.
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        for (int i = 0; i < 7; i++) step();
        in_valid = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_result", int'(result), 0);
        for (int i = 0; i < 20; i++) step();
        check("abort_still_idle", int'(busy), 0);
        prev_result = 0;

`ifndef SC_S2B_AUTORESTART_EN
        run_window(tbl[0]);
`else
        start = 1'b1;
        step();
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < 16; n++) begin
                if (n == 0) check("auto_busy_accum", int'(busy), 1);
                in_valid = 1'b1;
                in_bit   = (w == 1) ? ((n % 2) == 0) : 1'b1;
                if (n == 15) sb.push_back('{(w == 1) ? 8 : 16, cyc + 1});
                step();
            end
            check("auto_busy_done", int'(busy), 0);
            in_valid = 1'b1;
            in_bit   = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        // 256-bit window fed by a 2:1 mux adder over LFSR streams p=0.75/0.25.
        la = 16'hACE1;
        lb = 16'h3C5A;
        lc = 16'h9B27;
        cnt8 = 0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        valid8 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            la = {la[14:0], la[15] ^ la[13] ^ la[12] ^ la[10]};
            lb = {lb[14:0], lb[15] ^ lb[13] ^ lb[12] ^ lb[10]};
            lc = {lc[14:0], lc[15] ^ lc[13] ^ lc[12] ^ lc[10]};
            a = la[15:8] < 8'd192;
            b = lb[7:0] < 8'd64;
            bit8 = lc[3] ? a : b;
            cnt8 += int'(bit8);
            step();
        end
        valid8 = 1'b0;
        bit8 = 1'b0;
        check("w8_out_valid", int'(ov8), 1);
        check("w8_result", int'(result8), cnt8);
        check("w8_in_range", int'(result8 >= 9'd104 && result8 <= 9'd152), 1);
        step();
        check("w8_pulse_one_cycle", int'(ov8), 0);

        step();
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
